counter_nbit_up_down: RTL and testbench
=======================================

# counter_nbit_up_down

Free-running N-bit bidirectional ("ping-pong") counter. After reset it counts up from 0 to the all-ones value, then counts down to 0, and repeats indefinitely with no external control. It is a self-contained sequence and pattern source for test scaffolding and simple waveform generation. It has no enable or load; the only inputs are clock and reset.

## Interface
- WIDTH, default 3: counter width in bits; legal range ≥ 1.
- clock  input  1  rising-edge clock; the only clock domain.
- resetn  input  1  reset, asynchronous and active-high. The name is kept for codebase consistency; logic 1 resets.
- Q  output  WIDTH  current count value, driven directly from a register.

## Operation
- Internal state:
  - Count register Q, unsigned, WIDTH bits.
  - Direction register dir, one of {UP, DOWN}.
- Reset (resetn = 1): Q = 0 and dir = UP, immediately and independent of clock. Both hold while reset is asserted.
- Each rising clock edge with reset deasserted:
  - dir = UP, Q < MAX (2^WIDTH − 1): Q ← Q + 1, dir stays UP.
  - dir = UP, Q = MAX: dir ← DOWN, Q ← MAX − 1. The counter turns around with no dwell cycle.
  - dir = DOWN, Q > 0: Q ← Q − 1, dir stays DOWN.
  - dir = DOWN, Q = 0: dir ← UP, Q ← 1.
- WIDTH = 1 special case: Q toggles every cycle (0,1,0,1…), and dir toggles alongside it.
- Arithmetic is unsigned and WIDTH bits wide. Q never wraps modulo 2^WIDTH; the turnaround rules keep it inside 0..MAX.
- Resulting sequence for WIDTH = 3 from reset: 0,1,2,3,4,5,6,7,6,5,4,3,2,1,0,1,2…
- Period: 2·(2^WIDTH − 1) cycles; 14 for WIDTH = 3. Each endpoint appears once per period; interior values appear twice.
- Reset mid-sequence, in either direction: Q returns to 0 and dir to UP asynchronously. Counting restarts upward on the first rising edge after deassertion.
- No X/unknown state is reachable after the first reset assertion.

## Timing
- Latency: Q updates on each rising edge; one step per cycle. Q is registered with no combinational path from any input.
- Reset assertion: Q = 0 within the same delta/propagation time, with no clock required.
- Reset deassertion: the first rising edge after deassertion produces Q = 1.
  - If deassertion coincides with a rising edge, that edge counts as still in reset and Q remains 0; counting starts on the following edge.
- Simultaneous reset and clock edge: reset wins.

## Structure
- Shared package counter_pkg:
  - typedef enum logic {DIR_UP, DIR_DOWN} dir_t.
  - A function returning MAX for a given width.
- One sub-module, updown_dir_ctrl:
  - Inputs: current Q, current dir, and the MAX comparison flags at_max and at_zero.
  - Outputs: next dir and a step select (+1/−1), computed combinationally.
  - The top level holds the Q and dir registers and the adder/subtractor.
- All registers are in a single always_ff with asynchronous reset sensitivity.

## Test plan
- Power-up reset: hold resetn = 1 for 2 cycles, then release. Required: Q = 0 during reset; Q = 1,2,3 on the next three edges.
- Full period, WIDTH = 3: run 30 cycles after reset release. Required: Q follows 1..7,6..0,1..7,6,… with a period of 14 and no value outside 0..7.
- Turnaround points: check the edge after Q = 7 gives 6 (not 0), and the edge after Q = 0 in DOWN gives 1. No value repeats at either endpoint.
- Asynchronous mid-count reset: assert resetn between edges while counting down (for example at Q = 5). Required: Q = 0 before the next edge, and counting is upward after release.
- Reset coincident with clock edge: deassert exactly at a rising edge. Required: Q = 0 at that edge and Q = 1 at the next.
- Parameter sweep: WIDTH = 1 gives 0,1,0,1…; WIDTH = 4 peaks at 15 with a period of 30.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg: direction type and width helper for the up/down counter
package counter_pkg;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
  function automatic longint unsigned max_of(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction
endpackage

// File: rtl/updown_dir_ctrl.sv
// updown_dir_ctrl: turnaround decision and step select for the ping-pong counter
module updown_dir_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] q_i,
  input  dir_t             dir_i,
  input  logic             at_max_i,
  input  logic             at_zero_i,
  output dir_t             dir_o,
  output logic             step_up_o
);
  assign dir_o = (dir_i == DIR_UP) ? (at_max_i ? DIR_DOWN : DIR_UP)
                                   : (at_zero_i ? DIR_UP : DIR_DOWN);
  assign step_up_o = (dir_o == DIR_UP);
  // the endpoint flags must always agree with the count they were derived from
  always_comb assert (at_zero_i == (q_i == '0) && at_max_i == (q_i == WIDTH'(max_of(WIDTH))));
endmodule

// File: rtl/counter_nbit_up_down.sv
// counter_nbit_up_down: free-running ping-pong counter 0..MAX..0 with async reset
module counter_nbit_up_down
  import counter_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             resetn,
  output logic [WIDTH-1:0] Q
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(max_of(WIDTH));
  dir_t dir_q, dir_d;
  logic step_up;
  logic [WIDTH-1:0] q_d;
  updown_dir_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .q_i       (Q),
    .dir_i     (dir_q),
    .at_max_i  (Q == MAX),
    .at_zero_i (Q == '0),
    .dir_o     (dir_d),
    .step_up_o (step_up)
  );
  assign q_d = step_up ? Q + WIDTH'(1) : Q - WIDTH'(1);
  always_ff @(posedge clock or posedge resetn)
    if (resetn) begin
      Q     <= '0;
      dir_q <= DIR_UP;
    end else begin
      Q     <= q_d;
      dir_q <= dir_d;
    end
endmodule

// File: tb/tb_counter_nbit_up_down.sv
// tb_counter_nbit_up_down: directed checks of the ping-pong counter at widths 1, 3 and 4
module tb_counter_nbit_up_down;
  logic clock = 1'b0;
  logic resetn;
  logic [0:0] q1;
  logic [2:0] q3;
  logic [3:0] q4;
  int total = 0;
  int bad = 0;
  int exp3 [14] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1};

  always #5 clock = ~clock;

  counter_nbit_up_down #(.WIDTH(1)) u1 (.clock(clock), .resetn(resetn), .Q(q1));
  counter_nbit_up_down #(.WIDTH(3)) u3 (.clock(clock), .resetn(resetn), .Q(q3));
  counter_nbit_up_down #(.WIDTH(4)) u4 (.clock(clock), .resetn(resetn), .Q(q4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e1, input int e3, input int e4);
    chk({tag, " w1"}, 32'(q1), e1);
    chk({tag, " w3"}, 32'(q3), e3);
    chk({tag, " w4"}, 32'(q4), e4);
  endtask

  initial begin
    resetn = 1'b1;
    #1;
    chk_all("async reset", 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    chk_all("held reset", 0, 0, 0);
    #2 resetn = 1'b0;
    for (int k = 1; k <= 37; k++) begin
      @(posedge clock);
      #1;
      chk_all($sformatf("seq k=%0d", k), k % 2, exp3[k % 14],
              (k % 30) <= 15 ? (k % 30) : 30 - (k % 30));
    end
    #2 resetn = 1'b1;
    #1;
    chk_all("mid reset down", 0, 0, 0);
    @(posedge clock);
    #1;
    chk_all("reset holds", 0, 0, 0);
    @(posedge clock);
    resetn <= 1'b0;
    #1;
    chk_all("release at edge", 0, 0, 0);
    @(posedge clock);
    #1;
    chk_all("first count", 1, 1, 1);
    @(posedge clock);
    #1;
    chk_all("second count", 0, 2, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
